top: RTL and testbench
======================

// Module: top
// PURPOSE
//   Byte-to-dual-seven-segment hex display driver. Registers an 8-bit value and
//   drives two 7-segment digits (plus decimal point) showing it as two hex chars.
//   Digit 1 shows the upper nibble; digit 2 shows the lower nibble.
//   Sits at the board top level, between the value source and the LED pins.
// PARAMETERS
//   SEG_ACTIVE_LOW  default 0  1 = invert all 8 output bits (common-anode board)
// PORTS
//   clk            input   1  single system clock, rising edge
//   reset          input   1  asynchronous, active-high reset
//   Value          input   8  byte to display, sampled every clk edge
//   SevenSegDig1   output  8  {dp,g,f,e,d,c,b,a} pattern for Value[7:4]
//   SevenSegDig2   output  8  {dp,g,f,e,d,c,b,a} pattern for Value[3:0]
// BEHAVIOUR
//   - One clock, clk. Reset is asynchronous and active-high.
//   - Reset: the internal value register clears and both digits go blank
//     immediately: 8'h00 (8'hFF when SEG_ACTIVE_LOW=1). They stay blank until
//     the first rising clk edge after reset deasserts.
//   - Each rising clk edge with reset low captures Value into an 8-bit register.
//   - Both outputs are registered. Latency is exactly 1 clk from Value to
//     SevenSegDig1/2. There is no handshake; Value is sampled on every edge.
//   - Bit order, active-high: bit0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g, 7=dp.
//   - dp (bit 7) is always 0 when active-high.
//   - Encoding table (active-high, hex):
//       0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//       8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//   - SEG_ACTIVE_LOW=1: outputs are the bitwise inverse of the table,
//     including dp.
//   - All 256 inputs are valid; no illegal codes. Nibble 0 shows "0", not blank.
//   - Reset asserted mid-operation: outputs blank asynchronously. No partial
//     update of one digit only.
//   - Value changing between edges has no effect until the next edge.
// STRUCTURE
//   - Shared package holds the 16-entry SEG_* localparam table, the dp bit
//     index and the blank constant.
//   - Sub-module hex_to_7seg: a pure combinational 4-bit -> 7-bit decoder.
//     Instantiate it twice, once for [7:4] and once for [3:0].
//   - The top level holds the input register, the output registers, the dp
//     insertion and the polarity inversion.
// TESTING
//   - Reset: assert reset with Value=8'h7F -> both outputs 8'h00 with no clk
//     edge; still 8'h00 one edge after release with Value=8'h00? no ->
//     expect 8'h3F on both after that edge.
//   - Value=8'h7F, one clk edge -> SevenSegDig1=8'b00000111,
//     SevenSegDig2=8'b01110001.
//   - Latency: change Value 8'h12->8'hAB between edges -> outputs stay
//     06/5B until the next edge, then become 77/7C.
//   - Sweep: Value=8'h00..8'hFF, one edge each -> each digit matches the
//     table for its nibble; dp=0 throughout.
//   - Mid-run reset: stream 8'hC3, assert reset between edges -> outputs
//     blank immediately, not at the next edge.
//   - SEG_ACTIVE_LOW=1, Value=8'h80 -> SevenSegDig1=8'h80,
//     SevenSegDig2=8'hC0; after reset both =8'hFF.

Source files
------------

// File: rtl/hex7_pkg.sv
// Shared constants for the byte-to-dual-seven-segment display driver.
//   - SEG_0 .. SEG_F : active-high {g,f,e,d,c,b,a} patterns for each hex nibble
//   - DP_BIT         : bit index of the decimal point in the 8-bit output byte
//   - SEG_BLANK      : active-high pattern for an unlit digit (dp included)
package hex7_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DP_BIT = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  localparam logic [BYTE_W-1:0] SEG_BLANK = 8'h00;

endpackage : hex7_pkg

// File: rtl/hex_to_7seg.sv
// Pure combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble_i [3:0] : hex digit to show
//   seg_o    [6:0] : active-high {g,f,e,d,c,b,a} segment pattern
module hex_to_7seg
  import hex7_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    // NOTE: a combinational case must assign its output on every path;
    // the default-first assignment below guarantees no latch is inferred.
    seg_o = SEG_0;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_0;
    endcase
  end

endmodule : hex_to_7seg

// File: rtl/top.sv
// Byte-to-dual-seven-segment hex display driver.
// Value is sampled on every rising clk edge and shown one clock later as two
// hex characters: SevenSegDig1 for Value[7:4], SevenSegDig2 for Value[3:0].
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-high; blanks both digits immediately
//   Value [7:0]  : byte to display
//   SevenSegDig1 : {dp,g,f,e,d,c,b,a} for the upper nibble
//   SevenSegDig2 : {dp,g,f,e,d,c,b,a} for the lower nibble
// Parameter:
//   SEG_ACTIVE_LOW : 1 inverts all eight output bits (common-anode boards)
module top
  import hex7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] Value,
  output logic [BYTE_W-1:0] SevenSegDig1,
  output logic [BYTE_W-1:0] SevenSegDig2
);

  // XOR mask applied to every output byte, dp included.
  localparam logic [BYTE_W-1:0] POL_MASK  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [BYTE_W-1:0] BLANK_OUT = SEG_BLANK ^ POL_MASK;

  logic [SEG_W-1:0]  seg_hi;
  logic [SEG_W-1:0]  seg_lo;
  logic [BYTE_W-1:0] dig1_d, dig1_q;
  logic [BYTE_W-1:0] dig2_d, dig2_q;

  // Decoders work on the live input so the value register and the output
  // register are one and the same: the byte is captured already encoded,
  // which gives exactly one clock of latency.
  hex_to_7seg u_dec_hi (
    .nibble_i (Value[7:4]),
    .seg_o    (seg_hi)
  );

  hex_to_7seg u_dec_lo (
    .nibble_i (Value[3:0]),
    .seg_o    (seg_lo)
  );

  always_comb begin
    dig1_d = {1'b0, seg_hi};
    dig2_d = {1'b0, seg_lo};
    // dp is never lit on this board.
    dig1_d[DP_BIT] = 1'b0;
    dig2_d[DP_BIT] = 1'b0;
    dig1_d = dig1_d ^ POL_MASK;
    dig2_d = dig2_d ^ POL_MASK;
  end

  // Both digits share one register stage and one reset, so they can never
  // update or blank independently of each other.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      dig1_q <= BLANK_OUT;
      dig2_q <= BLANK_OUT;
    end else begin
      dig1_q <= dig1_d;
      dig2_q <= dig2_d;
    end
  end

  assign SevenSegDig1 = dig1_q;
  assign SevenSegDig2 = dig2_q;

endmodule : top

// File: tb/tb_top.sv
// Self-checking bench for the dual seven-segment driver. Two instances run
// side by side from the same stimulus: one active-high, one active-low.
// The reference model describes each hex glyph by the segment letters it
// lights and builds the expected byte from that description.
module tb_top;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Value;
  logic [7:0] dig1_h, dig2_h;
  logic [7:0] dig1_l, dig2_l;

  int errors = 0;
  int checks = 0;

  string glyph [16];

  top #(.SEG_ACTIVE_LOW(1'b0)) dut_h (
    .clk          (clk),
    .reset        (reset),
    .Value        (Value),
    .SevenSegDig1 (dig1_h),
    .SevenSegDig2 (dig2_h)
  );

  top #(.SEG_ACTIVE_LOW(1'b1)) dut_l (
    .clk          (clk),
    .reset        (reset),
    .Value        (Value),
    .SevenSegDig1 (dig1_l),
    .SevenSegDig2 (dig2_l)
  );

  always #5 clk = ~clk;

  // Segment letters lit for each hex character on a standard display.
  initial begin
    glyph[0]  = "abcdef";  glyph[1]  = "bc";      glyph[2]  = "abdeg";
    glyph[3]  = "abcdg";   glyph[4]  = "bcfg";    glyph[5]  = "acdfg";
    glyph[6]  = "acdefg";  glyph[7]  = "abc";     glyph[8]  = "abcdefg";
    glyph[9]  = "abcdfg";  glyph[10] = "abcefg";  glyph[11] = "cdefg";
    glyph[12] = "adef";    glyph[13] = "bcdeg";   glyph[14] = "adefg";
    glyph[15] = "aefg";
  end

  function automatic logic [7:0] model(input logic [3:0] nib, input bit act_low);
    logic [7:0] pat;
    string s;
    pat = 8'h00;
    s = glyph[nib];
    for (int i = 0; i < s.len(); i++) pat[s[i] - "a"] = 1'b1;
    return act_low ? ~pat : pat;
  endfunction

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Value = 8'h7F;
    #2;  // before the first clock edge
    checks++;
    if (dig1_h !== 8'h00 || dig2_h !== 8'h00) begin
      errors++;
      $display("FAIL reset_blank_high: got %h/%h want 00/00", dig1_h, dig2_h);
    end
    checks++;
    if (dig1_l !== 8'hFF || dig2_l !== 8'hFF) begin
      errors++;
      $display("FAIL reset_blank_low: got %h/%h want FF/FF", dig1_l, dig2_l);
    end
    step();
    @(negedge clk);
    reset = 1'b0;
    Value = 8'h00;
    #1;
    checks++;
    if (dig1_h !== 8'h00 || dig2_h !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold_until_edge: got %h/%h want 00/00", dig1_h, dig2_h);
    end
    step();
    checks++;
    if (dig1_h !== 8'h3F || dig2_h !== 8'h3F) begin
      errors++;
      $display("FAIL first_edge_zero: got %h/%h want 3F/3F", dig1_h, dig2_h);
    end
  endtask

  task automatic test_basic();
    Value = 8'h7F;
    step();
    checks++;
    if (dig1_h !== 8'b0000_0111 || dig2_h !== 8'b0111_0001) begin
      errors++;
      $display("FAIL basic_7F: got %h/%h want 07/71", dig1_h, dig2_h);
    end
    checks++;
    if (dig1_l !== 8'hF8 || dig2_l !== 8'h8E) begin
      errors++;
      $display("FAIL basic_7F_low: got %h/%h want F8/8E", dig1_l, dig2_l);
    end
  endtask

  task automatic test_latency();
    Value = 8'h12;
    step();
    checks++;
    if (dig1_h !== 8'h06 || dig2_h !== 8'h5B) begin
      errors++;
      $display("FAIL latency_12: got %h/%h want 06/5B", dig1_h, dig2_h);
    end
    @(negedge clk);
    Value = 8'hAB;
    #1;
    checks++;
    if (dig1_h !== 8'h06 || dig2_h !== 8'h5B) begin
      errors++;
      $display("FAIL latency_hold: got %h/%h want 06/5B", dig1_h, dig2_h);
    end
    step();
    checks++;
    if (dig1_h !== 8'h77 || dig2_h !== 8'h7C) begin
      errors++;
      $display("FAIL latency_AB: got %h/%h want 77/7C", dig1_h, dig2_h);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      Value = v;
      step();
      checks++;
      if (dig1_h !== model(v[7:4], 1'b0) || dig2_h !== model(v[3:0], 1'b0)) begin
        errors++;
        $display("FAIL sweep_high v=%h: got %h/%h want %h/%h", v, dig1_h, dig2_h,
                 model(v[7:4], 1'b0), model(v[3:0], 1'b0));
      end
      checks++;
      if (dig1_l !== model(v[7:4], 1'b1) || dig2_l !== model(v[3:0], 1'b1)) begin
        errors++;
        $display("FAIL sweep_low v=%h: got %h/%h want %h/%h", v, dig1_l, dig2_l,
                 model(v[7:4], 1'b1), model(v[3:0], 1'b1));
      end
      checks++;
      if (dig1_h[7] !== 1'b0 || dig2_h[7] !== 1'b0) begin
        errors++;
        $display("FAIL sweep_dp v=%h: got %b/%b want 0/0", v, dig1_h[7], dig2_h[7]);
      end
    end
  endtask

  // Random values, with a decoy value between edges that must be ignored.
  task automatic test_random();
    logic [7:0] v;
    for (int i = 0; i < 300; i++) begin
      v = 8'($urandom);
      Value = v;
      @(posedge clk);
      #1;
      Value = 8'($urandom);
      checks++;
      if (dig1_h !== model(v[7:4], 1'b0) || dig2_h !== model(v[3:0], 1'b0) ||
          dig1_l !== model(v[7:4], 1'b1) || dig2_l !== model(v[3:0], 1'b1)) begin
        errors++;
        $display("FAIL random v=%h: got %h/%h %h/%h want %h/%h %h/%h", v,
                 dig1_h, dig2_h, dig1_l, dig2_l,
                 model(v[7:4], 1'b0), model(v[3:0], 1'b0),
                 model(v[7:4], 1'b1), model(v[3:0], 1'b1));
      end
    end
  endtask

  task automatic test_midrun_reset();
    Value = 8'hC3;
    step();
    step();
    checks++;
    if (dig1_h !== 8'h39 || dig2_h !== 8'h4F) begin
      errors++;
      $display("FAIL midrun_pre: got %h/%h want 39/4F", dig1_h, dig2_h);
    end
    #1;
    reset = 1'b1;
    #1;  // well before the next rising edge
    checks++;
    if (dig1_h !== 8'h00 || dig2_h !== 8'h00 || dig1_l !== 8'hFF || dig2_l !== 8'hFF) begin
      errors++;
      $display("FAIL midrun_blank: got %h/%h %h/%h want 00/00 FF/FF",
               dig1_h, dig2_h, dig1_l, dig2_l);
    end
    step();
    checks++;
    if (dig1_h !== 8'h00 || dig2_h !== 8'h00) begin
      errors++;
      $display("FAIL midrun_held: got %h/%h want 00/00", dig1_h, dig2_h);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if (dig1_h !== 8'h39 || dig2_h !== 8'h4F) begin
      errors++;
      $display("FAIL midrun_resume: got %h/%h want 39/4F", dig1_h, dig2_h);
    end
  endtask

  task automatic test_active_low();
    Value = 8'h80;
    step();
    checks++;
    if (dig1_l !== 8'h80 || dig2_l !== 8'hC0) begin
      errors++;
      $display("FAIL active_low_80: got %h/%h want 80/C0", dig1_l, dig2_l);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (dig1_l !== 8'hFF || dig2_l !== 8'hFF) begin
      errors++;
      $display("FAIL active_low_reset: got %h/%h want FF/FF", dig1_l, dig2_l);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_sweep();
    test_random();
    test_midrun_reset();
    test_active_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_top
